// File: rtl/bitonic_sort_pipe_pkg.sv
// Shared constants and helpers for the pipelined bitonic sorter.
// Optional feature macro: SORT_IDX_EN (argsort tags and index tie-break).
package sort_pkg;

    localparam logic DIR_ASC  = 1'b0;
    localparam logic DIR_DESC = 1'b1;

    // Keys are widened to this many bits before comparing (sign- or zero-extended),
    // which lets one comparator serve every DATA_WIDTH up to 64.
    localparam int CMP_W = 65;

    // One register column per compare-exchange column of the network.
    function automatic int stage_cnt(input int log_n);
        return log_n * (log_n + 1) / 2;
    endfunction

    function automatic logic cmp_gt(input logic [CMP_W-1:0] a,
                                    input logic [CMP_W-1:0] b,
                                    input logic             signed_en);
        if (signed_en) return $signed(a) > $signed(b);
        return a > b;
    endfunction

endpackage

// File: rtl/bitonic_sort_pipe_cas_cell.sv
// Combinational compare-and-swap cell: lo position receives the element that
// belongs first for the given direction (smaller when ascending).
// With SORT_IDX_EN, equal keys are ordered by original index, lowest first,
// independent of the vector's overall direction.
module sort_cas_cell
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_W      = 3,
    parameter int SIGNED     = 0
) (
    input  logic                  desc_i,
    input  logic [DATA_WIDTH-1:0] a_key_i,
    input  logic [DATA_WIDTH-1:0] b_key_i,
    output logic [DATA_WIDTH-1:0] lo_key_o,
    output logic [DATA_WIDTH-1:0] hi_key_o
`ifdef SORT_IDX_EN
   ,input  logic                  dir_i,
    input  logic [IDX_W-1:0]      a_idx_i,
    input  logic [IDX_W-1:0]      b_idx_i,
    output logic [IDX_W-1:0]      lo_idx_o,
    output logic [IDX_W-1:0]      hi_idx_o
`endif
);

    logic a_gt_b, b_gt_a, swap;

    function automatic logic [CMP_W-1:0] ext(input logic [DATA_WIDTH-1:0] k);
        logic [CMP_W-1:0] e;
        e = '0;
        e[DATA_WIDTH-1:0] = k;
        for (int b = DATA_WIDTH; b < CMP_W; b++) e[b] = (SIGNED != 0) & k[DATA_WIDTH-1];
        return e;
    endfunction

    // Decide whether the pair must be exchanged; ties keep their positions
    // unless index tags are present to break them.
    always_comb begin
        a_gt_b = cmp_gt(ext(a_key_i), ext(b_key_i), SIGNED != 0);
        b_gt_a = cmp_gt(ext(b_key_i), ext(a_key_i), SIGNED != 0);
`ifdef SORT_IDX_EN
        // A descending vector sorts on {key, ~idx} in reverse, so equal keys
        // still leave with ascending original index.
        if (a_key_i == b_key_i) begin
            a_gt_b = (a_idx_i ^ {IDX_W{dir_i}}) > (b_idx_i ^ {IDX_W{dir_i}});
            b_gt_a = (b_idx_i ^ {IDX_W{dir_i}}) > (a_idx_i ^ {IDX_W{dir_i}});
        end
`endif
        swap     = desc_i ? b_gt_a : a_gt_b;
        lo_key_o = swap ? b_key_i : a_key_i;
        hi_key_o = swap ? a_key_i : b_key_i;
`ifdef SORT_IDX_EN
        lo_idx_o = swap ? b_idx_i : a_idx_i;
        hi_idx_o = swap ? a_idx_i : b_idx_i;
`endif
    end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter, one vector per cycle, global-stall handshake.
// Every compare-exchange column is followed by a register column, so a vector
// appears at the output S = LOG_N*(LOG_N+1)/2 cycles after it is accepted.
// Optional feature macro: SORT_IDX_EN adds out_idx (argsort) and index tie-break.
module bitonic_sort_pipe
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LOG_N      = 3,
    parameter int SIGNED     = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_dir,
    input  logic [(2**LOG_N)*DATA_WIDTH-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_dir,
    output logic [(2**LOG_N)*DATA_WIDTH-1:0] out_data
`ifdef SORT_IDX_EN
   ,output logic [(2**LOG_N)*LOG_N-1:0]      out_idx
`endif
);

    localparam int N = 2 ** LOG_N;
    localparam int S = stage_cnt(LOG_N);

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

    logic         en, accept;
    vec_t         key_in [S];
    vec_t         key_d  [S];
    vec_t         key_q  [S];
    logic [S-1:0] vld_d, vld_q, dir_src, dir_q;

`ifdef SORT_IDX_EN
    typedef logic [N-1:0][LOG_N-1:0] tag_t;
    tag_t tag_in [S];
    tag_t tag_d  [S];
    tag_t tag_q  [S];
`endif

    // The whole pipe advances together; it only stops when the output is full and blocked.
    assign en       = out_ready | ~vld_q[S-1];
    assign in_ready = en;
    assign accept   = in_valid & en;

    // Stage sources: the input port feeds column 0, each later column reads its predecessor.
    always_comb begin
        vld_d      = '0;
        dir_src    = '0;
        vld_d[0]   = accept;
        dir_src[0] = in_dir;
        for (int s = 1; s < S; s++) begin
            vld_d[s]   = vld_q[s-1];
            dir_src[s] = dir_q[s-1];
        end
    end

    for (genvar s = 0; s < S; s++) begin : g_src
        if (s == 0) begin : g_first
            assign key_in[s] = in_data;
`ifdef SORT_IDX_EN
            for (genvar i = 0; i < N; i++) begin : g_tag
                assign tag_in[s][i] = LOG_N'(i);
            end
`endif
        end else begin : g_rest
            assign key_in[s] = key_q[s-1];
`ifdef SORT_IDX_EN
            assign tag_in[s] = tag_q[s-1];
`endif
        end
    end

    // Network: block size 2^k, partner distance 2^J; column index counts all prior columns.
    for (genvar k = 1; k <= LOG_N; k++) begin : g_k
        for (genvar jj = 0; jj < k; jj++) begin : g_j
            localparam int J  = k - 1 - jj;
            localparam int ST = (k - 1) * k / 2 + jj;
            for (genvar i = 0; i < N; i++) begin : g_i
                if (((i >> J) & 1) == 0) begin : g_cell
                    localparam int   P    = i + (1 << J);
                    localparam logic BITK = (k == LOG_N) ? 1'b0 : 1'(((i >> k) & 1));
                    sort_cas_cell #(
                        .DATA_WIDTH(DATA_WIDTH),
                        .IDX_W     (LOG_N),
                        .SIGNED    (SIGNED)
                    ) u_cas (
                        .desc_i  (BITK ^ dir_src[ST]),
                        .a_key_i (key_in[ST][i]),
                        .b_key_i (key_in[ST][P]),
                        .lo_key_o(key_d[ST][i]),
                        .hi_key_o(key_d[ST][P])
`ifdef SORT_IDX_EN
                       ,.dir_i   (dir_src[ST]),
                        .a_idx_i (tag_in[ST][i]),
                        .b_idx_i (tag_in[ST][P]),
                        .lo_idx_o(tag_d[ST][i]),
                        .hi_idx_o(tag_d[ST][P])
`endif
                    );
                end
            end
        end
    end

    // Register columns: reset discards everything in flight; a stall freezes every column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dir_q <= '0;
            for (int s = 0; s < S; s++) begin
                key_q[s] <= '0;
`ifdef SORT_IDX_EN
                tag_q[s] <= '0;
`endif
            end
        end else if (en) begin
            vld_q <= vld_d;
            dir_q <= dir_src;
            key_q <= key_d;
`ifdef SORT_IDX_EN
            tag_q <= tag_d;
`endif
        end
    end

    assign out_valid = vld_q[S-1];
    assign out_dir   = dir_q[S-1];
    assign out_data  = key_q[S-1];
`ifdef SORT_IDX_EN
    assign out_idx   = tag_q[S-1];
`endif

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Bench for bitonic_sort_pipe (DATA_WIDTH=8, LOG_N=3): one unsigned and one
// signed instance share all inputs. Directed table, backpressure, reset and
// random streaming checked against a stable insertion-sort model.
module tb_bitonic_sort_pipe;

    localparam int DW = 8;
    localparam int LN = 3;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_dir = 1'b0, out_ready = 1'b1;
    logic [63:0]   in_data = '0;
    logic          in_ready_u, out_valid_u, out_dir_u;
    logic          in_ready_s, out_valid_s, out_dir_s;
    logic [63:0]   out_data_u, out_data_s;
`ifdef SORT_IDX_EN
    logic [23:0]   out_idx_u, out_idx_s;
`endif

    int n_chk = 0;
    int n_err = 0;
    int rx_cnt = 0;
    bit sb_on = 0;

    always #5 clk = ~clk;

    bitonic_sort_pipe #(.DATA_WIDTH(DW), .LOG_N(LN), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_dir(in_dir), .in_data(in_data), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_dir(out_dir_u), .out_data(out_data_u)
`ifdef SORT_IDX_EN
       ,.out_idx(out_idx_u)
`endif
    );

    bitonic_sort_pipe #(.DATA_WIDTH(DW), .LOG_N(LN), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_dir(in_dir), .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_dir(out_dir_s), .out_data(out_data_s)
`ifdef SORT_IDX_EN
       ,.out_idx(out_idx_s)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: stable insertion sort on integer keys; ties keep input order.
    function automatic void model(input logic [63:0] din, input logic dir, input logic sgn,
                                  output logic [63:0] dout, output logic [23:0] didx);
        int k[8];
        int ix[8];
        int t;
        for (int i = 0; i < N; i++) begin
            k[i]  = sgn ? int'($signed(din[i*8 +: 8])) : int'(din[i*8 +: 8]);
            ix[i] = i;
        end
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (dir ? (k[j-1] < k[j]) : (k[j-1] > k[j])) begin
                    t = k[j-1];  k[j-1]  = k[j];  k[j]  = t;
                    t = ix[j-1]; ix[j-1] = ix[j]; ix[j] = t;
                end
            end
        end
        dout = '0;
        didx = '0;
        for (int i = 0; i < N; i++) begin
            dout[i*8 +: 8] = 8'(k[i]);
            didx[i*3 +: 3] = 3'(ix[i]);
        end
    endfunction

    typedef struct packed {
        logic [63:0] du;
        logic [63:0] ds;
        logic [23:0] iu;
        logic [23:0] is;
        logic        dir;
    } exp_t;
    exp_t exp_q[$];

    // Scoreboard: handshakes seen at the falling edge complete at the next rising edge.
    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            if (out_valid_u && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_spurious_out", 64'(out_valid_u), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_data_u", out_data_u, e.du);
                    chk("sb_data_s", out_data_s, e.ds);
                    chk("sb_dir", 64'(out_dir_u), 64'(e.dir));
                    chk("sb_valid_s", 64'(out_valid_s), 64'd1);
`ifdef SORT_IDX_EN
                    chk("sb_idx_u", 64'(out_idx_u), 64'(e.iu));
                    chk("sb_idx_s", 64'(out_idx_s), 64'(e.is));
`endif
                    rx_cnt++;
                end
            end
            if (in_valid && in_ready_u) begin
                exp_t e;
                model(in_data, in_dir, 1'b0, e.du, e.iu);
                model(in_data, in_dir, 1'b1, e.ds, e.is);
                e.dir = in_dir;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the vector until the sorter takes it.
    task automatic send(input logic [63:0] d, input logic dr, output bit ok);
        in_data  = d;
        in_dir   = dr;
        in_valid = 1'b1;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (in_ready_u) ok = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] pack8(input logic [7:0] a[8]);
        logic [63:0] r;
        for (int i = 0; i < N; i++) r[i*8 +: 8] = a[i];
        return r;
    endfunction

    function automatic logic [23:0] pack3(input logic [2:0] a[8]);
        logic [23:0] r;
        for (int i = 0; i < N; i++) r[i*3 +: 3] = a[i];
        return r;
    endfunction

    typedef struct {
        string      name;
        logic [7:0] din[8];
        logic       dir;
        logic       sgn;
        logic [7:0] dexp[8];
        logic       has_idx;
        logic [2:0] iexp[8];
    } vec_rec_t;

    // Single vector through an idle pipe; returns cycles from accept to out_valid.
    task automatic apply_one(input logic [63:0] d, input logic dr, output int lat);
        out_ready = 1'b1;
        in_data   = d;
        in_dir    = dr;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready_u), 64'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_u && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        vec_rec_t    tbl[$];
        vec_rec_t    r;
        int          lat;
        bit          ok;
        logic [63:0] d0, ev;
        logic [23:0] ei;
        int          bad;

        r.has_idx = 0;
        r.iexp = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        r.name = "asc";      r.din = '{8'd7, 8'd3, 8'd5, 8'd1, 8'd0, 8'd6, 8'd2, 8'd4}; r.dir = 0; r.sgn = 0;
        r.dexp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7}; tbl.push_back(r);
        r.name = "desc";     r.dir = 1;
        r.dexp = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}; tbl.push_back(r);
        r.name = "signed";   r.din = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h10, 8'h90}; r.dir = 0; r.sgn = 1;
        r.dexp = '{8'h80, 8'h90, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h7F}; tbl.push_back(r);
        r.name = "unsigned"; r.sgn = 0;
        r.dexp = '{8'h00, 8'h01, 8'h10, 8'h7F, 8'h80, 8'h90, 8'hFE, 8'hFF}; tbl.push_back(r);
        r.name = "signed_desc"; r.dir = 1; r.sgn = 1;
        r.dexp = '{8'h7F, 8'h10, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'h90, 8'h80}; tbl.push_back(r);
`ifdef SORT_IDX_EN
        r.has_idx = 1; r.sgn = 0;
        r.name = "tie_asc";  r.din = '{8'd5, 8'd5, 8'd2, 8'd5, 8'd2, 8'd5, 8'd5, 8'd5}; r.dir = 0;
        r.dexp = '{8'd2, 8'd2, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5};
        r.iexp = '{3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd5, 3'd6, 3'd7}; tbl.push_back(r);
        r.name = "tie_desc"; r.dir = 1;
        r.dexp = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd2, 8'd2};
        r.iexp = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd6, 3'd7, 3'd2, 3'd4}; tbl.push_back(r);
`endif

        // Reset state.
        #2;
        chk("rst_out_valid", 64'(out_valid_u), 64'd0);
        chk("rst_out_data", out_data_u, 64'd0);
        chk("rst_out_dir", 64'(out_dir_u), 64'd0);
        chk("rst_in_ready", 64'(in_ready_u), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Directed table.
        foreach (tbl[t]) begin
            apply_one(pack8(tbl[t].din), tbl[t].dir, lat);
            chk({tbl[t].name, "_latency"}, 64'(lat), 64'd6);
            chk({tbl[t].name, "_data"}, tbl[t].sgn ? out_data_s : out_data_u, pack8(tbl[t].dexp));
            chk({tbl[t].name, "_dir"}, 64'(out_dir_u), 64'(tbl[t].dir));
`ifdef SORT_IDX_EN
            if (tbl[t].has_idx) chk({tbl[t].name, "_idx"}, 64'(out_idx_u), 64'(pack3(tbl[t].iexp)));
`endif
            step();
            chk({tbl[t].name, "_drained"}, 64'(out_valid_u), 64'd0);
        end

        // Backpressure: 10 back-to-back vectors, 4-cycle stall when vector 2 reaches the output.
        sb_on  = 1;
        rx_cnt = 0;
        fork
            begin
                for (int v = 0; v < 10; v++) begin
                    send({$urandom, $urandom}, 1'(v & 1), ok);
                    if (!ok) chk("bp_send_timeout", 64'd0, 64'd1);
                end
            end
            begin
                int c;
                c = 0;
                while (!(out_valid_u && rx_cnt == 2) && c < 100) begin
                    step();
                    c++;
                end
                if (c >= 100) chk("bp_v2_timeout", 64'd0, 64'd1);
                out_ready = 1'b0;
                d0 = out_data_u;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 64'(in_ready_u), 64'd0);
                    chk("bp_valid_held", 64'(out_valid_u), 64'd1);
                    chk("bp_data_stable", out_data_u, d0);
                    step();
                end
                out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 50 && rx_cnt < 10; c++) step();
        chk("bp_rx_count", 64'(rx_cnt), 64'd10);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random streaming with random backpressure.
        rx_cnt = 0;
        fork
            begin
                for (int v = 0; v < 150; v++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send({$urandom, $urandom}, 1'($urandom_range(0, 1)), ok);
                    if (!ok) chk("rnd_send_timeout", 64'd0, 64'd1);
                end
            end
            begin
                for (int c = 0; c < 600 && rx_cnt < 150; c++) begin
                    out_ready = ($urandom_range(0, 9) < 7);
                    step();
                end
            end
        join
        out_ready = 1'b1;
        for (int c = 0; c < 50 && rx_cnt < 150; c++) step();
        chk("rnd_rx_count", 64'(rx_cnt), 64'd150);
        chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        sb_on = 0;
        step();

        // Reset with three vectors in flight.
        out_ready = 1'b1;
        in_data   = {$urandom, $urandom};
        in_dir    = 1'b0;
        in_valid  = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid_u), 64'd0);
        chk("mid_rst_data", out_data_u, 64'd0);
        @(negedge clk);
        chk("mid_rst_valid_hold", 64'(out_valid_u), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready_u), 64'd1);
        step();
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            step();
            if (out_valid_u || out_valid_s) bad++;
        end
        chk("post_rst_no_emit", 64'(bad), 64'd0);
        d0 = {$urandom, $urandom};
        model(d0, 1'b1, 1'b0, ev, ei);
        apply_one(d0, 1'b1, lat);
        chk("post_rst_latency", 64'(lat), 64'd6);
        chk("post_rst_data", out_data_u, ev);
        chk("post_rst_dir", 64'(out_dir_u), 64'd1);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

endmodule
